ldpc_iter_ctrl: RTL

- Iteration controller for the LDPC decoder core.
- Drives the counting side of the decode loop: sequences codeword load, check-node (CN) and variable-node (VN) update phases, and counts iterations.
- Stops on an all-zero syndrome (early termination) or on reaching the iteration limit, then reports the result through a valid/ready handshake.
- Sits between the top-level decoder FSM/host and the CN/VN processing units.

---
 rtl/ldpc_iter_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the LDPC decoder: sequences load, CN and VN phases,
// counts iterations and reports success or limit exhaustion over valid/ready.
module ldpc_iter_ctrl #(
  parameter int ITER_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [ITER_BITS-1:0] i_max_iter,
  output logic                 o_load_start,
  input  logic                 i_load_done,
  output logic                 o_cn_start,
  input  logic                 i_cn_done,
  output logic                 o_vn_start,
  input  logic                 i_vn_done,
  input  logic                 i_syndrome_ok,
  output logic                 o_busy,
  output logic [ITER_BITS-1:0] o_iter_count,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_success
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOAD,
    S_CN,
    S_WAIT_CN,
    S_VN,
    S_WAIT_VN,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [ITER_BITS-1:0] ITER_ONE = ITER_BITS'(1);
  localparam logic [ITER_BITS-1:0] ITER_MAX = '1;

  state_t                r_state;
  state_t                w_next;
  logic [ITER_BITS-1:0]  r_iter;
  logic [ITER_BITS-1:0]  r_limit;
  logic [ITER_BITS-1:0]  w_limit_eff;
  logic                  r_synd;
  logic                  r_success;
  logic                  w_accept;
  logic                  w_vn_take;
  logic                  w_set_success;

  // A zero limit still runs one full iteration.
  assign w_limit_eff  = (r_limit == '0) ? ITER_ONE : r_limit;
  assign o_busy       = (r_state != S_IDLE);
  assign o_iter_count = r_iter;
  assign o_success    = r_success;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_load_start  = 1'b0;
    o_cn_start    = 1'b0;
    o_vn_start    = 1'b0;
    o_out_valid   = 1'b0;
    w_accept      = 1'b0;
    w_vn_take     = 1'b0;
    w_set_success = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        o_load_start = 1'b1;
        w_next       = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        if (i_load_done) w_next = S_CN;
      end
      S_CN: begin
        o_cn_start = 1'b1;
        w_next     = S_WAIT_CN;
      end
      S_WAIT_CN: begin
        if (i_cn_done) w_next = S_VN;
      end
      S_VN: begin
        o_vn_start = 1'b1;
        w_next     = S_WAIT_VN;
      end
      S_WAIT_VN: begin
        if (i_vn_done) begin
          w_vn_take = 1'b1;
          w_next    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_synd) begin
          w_set_success = 1'b1;
          w_next        = S_DONE;
        end else if (r_iter >= w_limit_eff) begin
          w_next = S_DONE;
        end else begin
          w_next = S_CN;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every transition and silences pulses and the result.
    if (i_abort) begin
      w_next        = S_IDLE;
      o_load_start  = 1'b0;
      o_cn_start    = 1'b0;
      o_vn_start    = 1'b0;
      o_out_valid   = 1'b0;
      w_accept      = 1'b0;
      w_vn_take     = 1'b0;
      w_set_success = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iter    <= '0;
      r_limit   <= '0;
      r_synd    <= 1'b0;
      r_success <= 1'b0;
    end else if (i_abort) begin
      r_success <= 1'b0;
    end else begin
      if (w_accept) begin
        r_limit   <= i_max_iter;
        r_iter    <= '0;
        r_synd    <= 1'b0;
        r_success <= 1'b0;
      end
      if (w_vn_take) begin
        r_synd <= i_syndrome_ok;
        if (r_iter != ITER_MAX) r_iter <= r_iter + ITER_ONE;
      end
      if (w_set_success) r_success <= 1'b1;
    end
  end

endmodule
